// File: rtl/sn74_mux_arbiter.sv
// Two-requester round-robin controller for one SN74XX158-style inverting quad 2:1 mux.
// Each grant runs select -> strobe for HOLD cycles -> capture -> release -> acknowledge.
module sn74_mux_arbiter #(
  parameter int unsigned HOLD      = 2,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       mux_sel,
  output logic       mux_str,
  input  logic [3:0] mux_y,
  output logic [3:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       owner
);

  localparam int unsigned     CNT_W   = 4;
  localparam int unsigned     DATA_W  = 4;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRIVE,
    S_RELEASE
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_q;
  logic                ack_a_q, ack_b_q;
  logic                sel_q, str_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q, busy_q, owner_q;
  logic                winner_c;

  // Contention goes to whoever was not served last.
  always_comb begin
    winner_c = 1'b0;
    if (req_a && req_b) winner_c = ~last_q;
    else if (req_b)     winner_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= ~PRIO_INIT;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      sel_q      <= 1'b0;
      str_q      <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= PRIO_INIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_a || req_b) begin
            sel_q   <= winner_c;
            owner_q <= winner_c;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          str_q   <= 1'b0;
          cnt_q   <= HOLD_M1;
          state_q <= S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // Capture on the last strobed cycle, then park the outputs high.
            rd_data_q  <= ~mux_y;
            rd_valid_q <= 1'b1;
            ack_a_q    <= ~owner_q;
            ack_b_q    <= owner_q;
            str_q      <= 1'b1;
            last_q     <= owner_q;
            state_q    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ack_a_q    <= 1'b0;
          ack_b_q    <= 1'b0;
          rd_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign mux_sel  = sel_q;
  assign mux_str  = str_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_sn74_mux_arbiter.sv
// Directed bench for sn74_mux_arbiter: cycle vector table plus hand sequences,
// with HOLD=1 and HOLD=15 instances alongside the default HOLD=2 one.
module tb_sn74_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst, req_a, req_b, req1, req15;
  logic [3:0] a_dat, b_dat;

  logic       ack_a, ack_b, mux_sel, mux_str, rd_valid, busy, owner;
  logic [3:0] mux_y, rd_data;
  logic       ack_a1, ack_b1, sel1, str1, rv1, busy1, own1;
  logic [3:0] y1, rd1;
  logic       ack_a15, ack_b15, sel15, str15, rv15, busy15, own15;
  logic [3:0] y15, rd15;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural SN74XX158: inverted data while strobed, all ones when parked.
  assign mux_y = mux_str ? 4'hf : ~(mux_sel ? b_dat : a_dat);
  assign y1    = str1    ? 4'hf : ~(sel1    ? b_dat : a_dat);
  assign y15   = str15   ? 4'hf : ~(sel15   ? b_dat : a_dat);

  sn74_mux_arbiter #(.HOLD(2), .PRIO_INIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .ack_a(ack_a), .ack_b(ack_b), .mux_sel(mux_sel), .mux_str(mux_str),
    .mux_y(mux_y), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .owner(owner));

  sn74_mux_arbiter #(.HOLD(1), .PRIO_INIT(1'b0)) u_h1 (
    .clk(clk), .rst(rst), .req_a(req1), .req_b(1'b0),
    .ack_a(ack_a1), .ack_b(ack_b1), .mux_sel(sel1), .mux_str(str1),
    .mux_y(y1), .rd_data(rd1), .rd_valid(rv1), .busy(busy1), .owner(own1));

  sn74_mux_arbiter #(.HOLD(15), .PRIO_INIT(1'b0)) u_h15 (
    .clk(clk), .rst(rst), .req_a(req15), .req_b(1'b0),
    .ack_a(ack_a15), .ack_b(ack_b15), .mux_sel(sel15), .mux_str(str15),
    .mux_y(y15), .rd_data(rd15), .rd_valid(rv15), .busy(busy15), .owner(own15));

  typedef struct {
    logic        rst, ra, rb;
    logic [10:0] exp; // {ack_a, ack_b, sel, str, busy, owner, rd_valid, rd_data}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] mk(input logic aa, input logic ab, input logic sel,
                                     input logic str, input logic bsy, input logic own,
                                     input logic rv, input logic [3:0] rd);
    return {aa, ab, sel, str, bsy, own, rv, rd};
  endfunction

  task automatic add(input logic r, input logic ra, input logic rb, input logic [10:0] e);
    vec_t v;
    v.rst = r; v.ra = ra; v.rb = rb; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one edge, compare all main-instance outputs just after it.
  task automatic apply(input string name, input logic r, input logic ra, input logic rb,
                       input logic [10:0] e);
    rst = r; req_a = ra; req_b = rb;
    @(posedge clk); #1;
    chk(name, int'({ack_a, ack_b, mux_sel, mux_str, busy, owner, rd_valid, rd_data}), int'(e));
  endtask

  // Select must never move while the strobe is held low.
  logic prev_str = 1'b1;
  logic prev_sel = 1'b0;
  always @(negedge clk) begin
    if (!rst && !prev_str && !mux_str) chk("sel_stable_while_strobed", int'(mux_sel), int'(prev_sel));
    prev_str = mux_str;
    prev_sel = mux_sel;
  end

  int lat1, lat2, lat15, low1, low2, low15;
  logic [3:0] cap1, cap2, cap15;

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; req1 = 1'b0; req15 = 1'b0;
    a_dat = 4'ha; b_dat = 4'hf;

    // Reset with req_a held, then a single A transfer.
    add(1, 1, 0, mk(0, 0, 0, 1, 0, 0, 0, 4'h0));
    add(1, 1, 0, mk(0, 0, 0, 1, 0, 0, 0, 4'h0));
    add(0, 1, 0, mk(0, 0, 0, 1, 1, 0, 0, 4'h0));
    add(0, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'h0));
    add(0, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'h0));
    add(0, 1, 0, mk(1, 0, 0, 1, 1, 0, 1, 4'ha));
    add(0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 4'ha));
    add(0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 4'ha));
    // Continuous contention: B, A, B with acks 5 cycles apart.
    add(0, 1, 1, mk(0, 0, 1, 1, 1, 1, 0, 4'ha));
    add(0, 1, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'ha));
    add(0, 1, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'ha));
    add(0, 1, 1, mk(0, 1, 1, 1, 1, 1, 1, 4'hf));
    add(0, 1, 1, mk(0, 0, 1, 1, 0, 1, 0, 4'hf));
    add(0, 1, 1, mk(0, 0, 0, 1, 1, 0, 0, 4'hf));
    add(0, 1, 1, mk(0, 0, 0, 0, 1, 0, 0, 4'hf));
    add(0, 1, 1, mk(0, 0, 0, 0, 1, 0, 0, 4'hf));
    add(0, 1, 1, mk(1, 0, 0, 1, 1, 0, 1, 4'ha));
    add(0, 1, 1, mk(0, 0, 0, 1, 0, 0, 0, 4'ha));
    add(0, 1, 1, mk(0, 0, 1, 1, 1, 1, 0, 4'ha));
    add(0, 1, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'ha));
    add(0, 1, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'ha));
    add(0, 1, 1, mk(0, 1, 1, 1, 1, 1, 1, 4'hf));
    add(0, 0, 0, mk(0, 0, 1, 1, 0, 1, 0, 4'hf));
    add(0, 0, 0, mk(0, 0, 1, 1, 0, 1, 0, 4'hf));

    @(negedge clk);
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].exp);

    // Reset in the second DRIVE cycle of a B transfer aborts it without ack.
    apply("rst_b_grant",   0, 0, 1, mk(0, 0, 1, 1, 1, 1, 0, 4'hf));
    apply("rst_b_setup",   0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'hf));
    apply("rst_b_drive1",  0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'hf));
    apply("rst_abort",     1, 1, 1, mk(0, 0, 0, 1, 0, 0, 0, 4'h0));
    apply("post_rst_a",    0, 1, 1, mk(0, 0, 0, 1, 1, 0, 0, 4'h0));
    apply("post_rst_s",    0, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'h0));
    apply("post_rst_d",    0, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'h0));
    apply("post_rst_ack",  0, 1, 0, mk(1, 0, 0, 1, 1, 0, 1, 4'ha));
    apply("post_rst_rel",  0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 4'ha));

    // req_a dropped in SETUP still acks; req_b raised in DRIVE wins the next IDLE.
    apply("drop_grant",    0, 1, 0, mk(0, 0, 0, 1, 1, 0, 0, 4'ha));
    apply("drop_setup",    0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'ha));
    apply("late_b_drive",  0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 4'ha));
    apply("drop_ack_a",    0, 0, 1, mk(1, 0, 0, 1, 1, 0, 1, 4'ha));
    apply("drop_rel",      0, 0, 1, mk(0, 0, 0, 1, 0, 0, 0, 4'ha));
    apply("late_b_grant",  0, 0, 1, mk(0, 0, 1, 1, 1, 1, 0, 4'ha));
    apply("late_b_s",      0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'ha));
    apply("late_b_d",      0, 0, 1, mk(0, 0, 1, 0, 1, 1, 0, 4'ha));
    apply("late_b_ack",    0, 0, 1, mk(0, 1, 1, 1, 1, 1, 1, 4'hf));
    apply("late_b_rel",    0, 0, 0, mk(0, 0, 1, 1, 0, 1, 0, 4'hf));

    // Strobe width and ack latency for HOLD = 1, 2, 15 side by side.
    a_dat = 4'h3;
    apply("timing_rst",    1, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 4'h0));
    rst = 1'b0; req_a = 1'b1; req1 = 1'b1; req15 = 1'b1;
    lat1 = 0; lat2 = 0; lat15 = 0; low1 = 0; low2 = 0; low15 = 0;
    cap1 = 4'h0; cap2 = 4'h0; cap15 = 4'h0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (!str1)  low1++;
      if (!mux_str) low2++;
      if (!str15) low15++;
      if (ack_a1 && lat1 == 0)  begin lat1 = k;  cap1 = rd1;     req1 = 1'b0;  end
      if (ack_a && lat2 == 0)   begin lat2 = k;  cap2 = rd_data; req_a = 1'b0; end
      if (ack_a15 && lat15 == 0) begin lat15 = k; cap15 = rd15;  req15 = 1'b0; end
    end
    chk("hold1_latency",  lat1, 3);
    chk("hold2_latency",  lat2, 4);
    chk("hold15_latency", lat15, 17);
    chk("hold1_str_low",  low1, 1);
    chk("hold2_str_low",  low2, 2);
    chk("hold15_str_low", low15, 15);
    chk("hold1_rd",  int'(cap1), 3);
    chk("hold2_rd",  int'(cap2), 3);
    chk("hold15_rd", int'(cap15), 3);
    chk("idle_after_timing", int'({busy1, busy, busy15}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
